// File: rtl/reg_read_stage_pkg.sv
// Shared types for the register-read stage: operand widths, decoded op,
// trap record, the pipeline-register layout and its reset value.
package reg_read_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] uint64_t;
    typedef logic [4:0]  reg_addr_t;
    typedef logic [11:0] csr_addr_t;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_ALU    = 4'd1,
        OP_LOAD   = 4'd2,
        OP_STORE  = 4'd3,
        OP_BRANCH = 4'd4,
        OP_CSR    = 4'd5,
        OP_FPU    = 4'd6,
        OP_SYSTEM = 4'd7
    } Op;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
        word_t      value;
    } TrapInfo;

    localparam reg_addr_t ZeroRegAddr   = 5'd0;
    localparam TrapInfo   TrapInfoReset = '{valid: 1'b0, cause: 4'd0, value: 32'd0};

    typedef struct packed {
        logic      valid;
        Op         op;
        word_t     pc;
        word_t     insn;
        csr_addr_t csrAddr;
        reg_addr_t srcRegAddr1;
        reg_addr_t srcRegAddr2;
        reg_addr_t dstRegAddr;
        word_t     srcIntRegValue1;
        word_t     srcIntRegValue2;
        uint64_t   srcFpRegValue1;
        uint64_t   srcFpRegValue2;
        TrapInfo   trapInfo;
    } RegReadStageReg;

    localparam RegReadStageReg RegReadStageRegReset = '{
        valid:           1'b0,
        op:              OP_NOP,
        pc:              32'd0,
        insn:            32'd0,
        csrAddr:         12'd0,
        srcRegAddr1:     5'd0,
        srcRegAddr2:     5'd0,
        dstRegAddr:      5'd0,
        srcIntRegValue1: 32'd0,
        srcIntRegValue2: 32'd0,
        srcFpRegValue1:  64'd0,
        srcFpRegValue2:  64'd0,
        trapInfo:        TrapInfoReset
    };

endpackage

// File: rtl/reg_read_stage_if.sv
// Register-read -> execute interface. ThisStage drives the registered
// stage contents; NextStage consumes them.
interface RegReadStageIF;
    import reg_read_stage_pkg::*;

    RegReadStageReg regs;

    modport ThisStage (output regs);
    modport NextStage (input  regs);

endinterface

// File: rtl/reg_read_bypass.sv
// Resolves one source operand from RF read data and the writeback ports.
// Writeback merge is compiled in only with RAFI_REG_READ_BYPASS_EN;
// otherwise the RF data passes through (integer x0 still reads zero).
module reg_read_bypass
    import reg_read_stage_pkg::*;
(
    input  reg_addr_t addr,
    input  word_t     int_rf_data,
    input  uint64_t   fp_rf_data,
    input  logic      wb_int_we,
    input  reg_addr_t wb_int_addr,
    input  word_t     wb_int_value,
    input  logic      wb_fp_we,
    input  reg_addr_t wb_fp_addr,
    input  uint64_t   wb_fp_value,
    output word_t     int_value,
    output uint64_t   fp_value
);

    // Same-cycle writeback wins over RF data; x0 is hardwired zero, f0 is not
    always_comb begin
        int_value = int_rf_data;
        fp_value  = fp_rf_data;
`ifdef RAFI_REG_READ_BYPASS_EN
        if (wb_int_we && (wb_int_addr == addr)) int_value = wb_int_value;
        if (wb_fp_we && (wb_fp_addr == addr))   fp_value  = wb_fp_value;
`endif
        if (addr == ZeroRegAddr) int_value = '0;
    end

`ifdef RAFI_REG_READ_BYPASS_EN
`else
    // Writeback ports stay on the port list but carry no meaning here
    logic wb_unused;
    assign wb_unused = ^{wb_int_we, wb_int_addr, wb_int_value,
                         wb_fp_we, wb_fp_addr, wb_fp_value};
`endif

endmodule

// File: rtl/reg_read_stage.sv
// Register-read pipeline stage: one pipeline register between decode and
// execute with flush > stall > load priority. Optional writeback merge and
// stalled-operand refresh are enabled by RAFI_REG_READ_BYPASS_EN.
module reg_read_stage
    import reg_read_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rstN,
    input  logic      prevValid,
    input  Op         prevOp,
    input  word_t     prevPc,
    input  word_t     prevInsn,
    input  csr_addr_t prevCsrAddr,
    input  reg_addr_t prevSrcRegAddr1,
    input  reg_addr_t prevSrcRegAddr2,
    input  reg_addr_t prevDstRegAddr,
    input  TrapInfo   prevTrapInfo,
    output reg_addr_t intRfAddr1,
    output reg_addr_t intRfAddr2,
    input  word_t     intRfData1,
    input  word_t     intRfData2,
    output reg_addr_t fpRfAddr1,
    output reg_addr_t fpRfAddr2,
    input  uint64_t   fpRfData1,
    input  uint64_t   fpRfData2,
    input  logic      wbIntWe,
    input  reg_addr_t wbIntAddr,
    input  word_t     wbIntValue,
    input  logic      wbFpWe,
    input  reg_addr_t wbFpAddr,
    input  uint64_t   wbFpValue,
    input  logic      stall,
    input  logic      flush,
    RegReadStageIF.ThisStage nextStage
);

    RegReadStageReg rr_q, rr_d;

    reg_addr_t byp_addr1, byp_addr2;
    word_t     byp_int_in1, byp_int_in2, res_int1, res_int2;
    uint64_t   byp_fp_in1, byp_fp_in2, res_fp1, res_fp2;

    assign intRfAddr1 = prevSrcRegAddr1;
    assign intRfAddr2 = prevSrcRegAddr2;
    assign fpRfAddr1  = prevSrcRegAddr1;
    assign fpRfAddr2  = prevSrcRegAddr2;

    // The bypass units resolve the incoming instruction on a load and
    // re-resolve the held instruction (its own values as "RF data") on a stall
    always_comb begin
        byp_addr1   = prevSrcRegAddr1;
        byp_addr2   = prevSrcRegAddr2;
        byp_int_in1 = intRfData1;
        byp_int_in2 = intRfData2;
        byp_fp_in1  = fpRfData1;
        byp_fp_in2  = fpRfData2;
        if (stall) begin
            byp_addr1   = rr_q.srcRegAddr1;
            byp_addr2   = rr_q.srcRegAddr2;
            byp_int_in1 = rr_q.srcIntRegValue1;
            byp_int_in2 = rr_q.srcIntRegValue2;
            byp_fp_in1  = rr_q.srcFpRegValue1;
            byp_fp_in2  = rr_q.srcFpRegValue2;
        end
    end

    reg_read_bypass u_byp1 (
        .addr         (byp_addr1),
        .int_rf_data  (byp_int_in1),
        .fp_rf_data   (byp_fp_in1),
        .wb_int_we    (wbIntWe),
        .wb_int_addr  (wbIntAddr),
        .wb_int_value (wbIntValue),
        .wb_fp_we     (wbFpWe),
        .wb_fp_addr   (wbFpAddr),
        .wb_fp_value  (wbFpValue),
        .int_value    (res_int1),
        .fp_value     (res_fp1)
    );

    reg_read_bypass u_byp2 (
        .addr         (byp_addr2),
        .int_rf_data  (byp_int_in2),
        .fp_rf_data   (byp_fp_in2),
        .wb_int_we    (wbIntWe),
        .wb_int_addr  (wbIntAddr),
        .wb_int_value (wbIntValue),
        .wb_fp_we     (wbFpWe),
        .wb_fp_addr   (wbFpAddr),
        .wb_fp_value  (wbFpValue),
        .int_value    (res_int2),
        .fp_value     (res_fp2)
    );

    // Next pipeline-register contents: flush kills, stall holds (with operand
    // refresh for a valid instruction), otherwise load from decode
    always_comb begin
        rr_d = rr_q;
        if (flush) begin
            rr_d = RegReadStageRegReset;
        end else if (stall) begin
            if (rr_q.valid) begin
                rr_d.srcIntRegValue1 = res_int1;
                rr_d.srcIntRegValue2 = res_int2;
                rr_d.srcFpRegValue1  = res_fp1;
                rr_d.srcFpRegValue2  = res_fp2;
            end
        end else begin
            rr_d.valid           = prevValid;
            rr_d.op              = prevOp;
            rr_d.pc              = prevPc;
            rr_d.insn            = prevInsn;
            rr_d.csrAddr         = prevCsrAddr;
            rr_d.srcRegAddr1     = prevSrcRegAddr1;
            rr_d.srcRegAddr2     = prevSrcRegAddr2;
            rr_d.dstRegAddr      = prevDstRegAddr;
            rr_d.srcIntRegValue1 = res_int1;
            rr_d.srcIntRegValue2 = res_int2;
            rr_d.srcFpRegValue1  = res_fp1;
            rr_d.srcFpRegValue2  = res_fp2;
            rr_d.trapInfo        = prevTrapInfo;
        end
    end

    // Pipeline register with asynchronous clear
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) rr_q <= RegReadStageRegReset;
        else       rr_q <= rr_d;
    end

    assign nextStage.regs = rr_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed + short random bench for reg_read_stage. Expected register
// contents come from a behavioural model and flow through a scoreboard queue.
module tb_reg_read_stage;
    import reg_read_stage_pkg::*;

`ifdef RAFI_REG_READ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic      clk, rstN, prevValid, stall, flush;
    Op         prevOp;
    word_t     prevPc, prevInsn, intRfData1, intRfData2, wbIntValue;
    csr_addr_t prevCsrAddr;
    reg_addr_t prevSrcRegAddr1, prevSrcRegAddr2, prevDstRegAddr;
    reg_addr_t intRfAddr1, intRfAddr2, fpRfAddr1, fpRfAddr2, wbIntAddr, wbFpAddr;
    TrapInfo   prevTrapInfo;
    uint64_t   fpRfData1, fpRfData2, wbFpValue;
    logic      wbIntWe, wbFpWe;

    RegReadStageIF rr_if();

    reg_read_stage dut (
        .clk(clk), .rstN(rstN), .prevValid(prevValid), .prevOp(prevOp),
        .prevPc(prevPc), .prevInsn(prevInsn), .prevCsrAddr(prevCsrAddr),
        .prevSrcRegAddr1(prevSrcRegAddr1), .prevSrcRegAddr2(prevSrcRegAddr2),
        .prevDstRegAddr(prevDstRegAddr), .prevTrapInfo(prevTrapInfo),
        .intRfAddr1(intRfAddr1), .intRfAddr2(intRfAddr2),
        .intRfData1(intRfData1), .intRfData2(intRfData2),
        .fpRfAddr1(fpRfAddr1), .fpRfAddr2(fpRfAddr2),
        .fpRfData1(fpRfData1), .fpRfData2(fpRfData2),
        .wbIntWe(wbIntWe), .wbIntAddr(wbIntAddr), .wbIntValue(wbIntValue),
        .wbFpWe(wbFpWe), .wbFpAddr(wbFpAddr), .wbFpValue(wbFpValue),
        .stall(stall), .flush(flush), .nextStage(rr_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             n_vec = 0;
    int             n_err = 0;
    RegReadStageReg model;
    RegReadStageReg sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rr(input string tag, input RegReadStageReg obs, input RegReadStageReg exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t exp_int(input reg_addr_t a, input word_t rf);
        if (a == 5'd0) return 32'h0;
        if (BYP && wbIntWe && wbIntAddr == a) return wbIntValue;
        return rf;
    endfunction

    function automatic uint64_t exp_fp(input reg_addr_t a, input uint64_t rf);
        if (BYP && wbFpWe && wbFpAddr == a) return wbFpValue;
        return rf;
    endfunction

    // Behavioural next-state of the pipeline register from current inputs
    function automatic RegReadStageReg predict(input RegReadStageReg cur);
        RegReadStageReg n;
        n = cur;
        if (flush) begin
            n = RegReadStageRegReset;
        end else if (stall) begin
            if (cur.valid && BYP) begin
                if (wbIntWe && wbIntAddr != 5'd0 && wbIntAddr == cur.srcRegAddr1) n.srcIntRegValue1 = wbIntValue;
                if (wbIntWe && wbIntAddr != 5'd0 && wbIntAddr == cur.srcRegAddr2) n.srcIntRegValue2 = wbIntValue;
                if (wbFpWe && wbFpAddr == cur.srcRegAddr1) n.srcFpRegValue1 = wbFpValue;
                if (wbFpWe && wbFpAddr == cur.srcRegAddr2) n.srcFpRegValue2 = wbFpValue;
            end
        end else begin
            n.valid = prevValid;           n.op = prevOp;
            n.pc = prevPc;                 n.insn = prevInsn;
            n.csrAddr = prevCsrAddr;       n.dstRegAddr = prevDstRegAddr;
            n.srcRegAddr1 = prevSrcRegAddr1;
            n.srcRegAddr2 = prevSrcRegAddr2;
            n.srcIntRegValue1 = exp_int(prevSrcRegAddr1, intRfData1);
            n.srcIntRegValue2 = exp_int(prevSrcRegAddr2, intRfData2);
            n.srcFpRegValue1  = exp_fp(prevSrcRegAddr1, fpRfData1);
            n.srcFpRegValue2  = exp_fp(prevSrcRegAddr2, fpRfData2);
            n.trapInfo = prevTrapInfo;
        end
        return n;
    endfunction

    // One clock: push the prediction, let the edge happen, pop and compare
    task automatic apply(input string tag);
        RegReadStageReg e;
        e = predict(model);
        sb_q.push_back(e);
        model = e;
        @(posedge clk);
        #1;
        chk_rr(tag, rr_if.regs, sb_q.pop_front());
    endtask

    task automatic set_instr(input word_t pc, input reg_addr_t s1, input reg_addr_t s2, input reg_addr_t d);
        prevValid = 1'b1;  prevOp = OP_ALU;
        prevPc = pc;       prevInsn = pc ^ 32'h0000_0013;
        prevCsrAddr = pc[11:0];
        prevSrcRegAddr1 = s1; prevSrcRegAddr2 = s2; prevDstRegAddr = d;
        prevTrapInfo = TrapInfoReset;
    endtask

    task automatic wb_off();
        wbIntWe = 1'b0; wbIntAddr = 5'd0; wbIntValue = 32'h0;
        wbFpWe  = 1'b0; wbFpAddr  = 5'd0; wbFpValue  = 64'h0;
    endtask

    initial begin
        rstN = 1'b1; stall = 1'b0; flush = 1'b0;
        set_instr(32'h0, 5'd0, 5'd0, 5'd0);
        prevValid = 1'b0;
        intRfData1 = 32'h0; intRfData2 = 32'h0; fpRfData1 = 64'h0; fpRfData2 = 64'h0;
        wb_off();

        // asynchronous reset, observed before any clock edge
        #2 rstN = 1'b0;
        #1;
        chk("reset_valid", 64'(rr_if.regs.valid), 64'h0);
        chk("reset_pc", 64'(rr_if.regs.pc), 64'h0);
        model = RegReadStageRegReset;
        chk_rr("reset_all", rr_if.regs, model);
        @(negedge clk);
        rstN = 1'b1;

        // basic load
        set_instr(32'h100, 5'd5, 5'd6, 5'd1);
        intRfData1 = 32'h11; intRfData2 = 32'h33;
        fpRfData1 = 64'h1111_0000_0000_0001; fpRfData2 = 64'h2222_0000_0000_0002;
        apply("basic_load");
        chk("basic_valid", 64'(rr_if.regs.valid), 64'h1);
        chk("basic_pc", 64'(rr_if.regs.pc), 64'h100);
        chk("basic_int1", 64'(rr_if.regs.srcIntRegValue1), 64'h11);

        // same-cycle writeback merge at load
        set_instr(32'h104, 5'd5, 5'd6, 5'd2);
        wbIntWe = 1'b1; wbIntAddr = 5'd5; wbIntValue = 32'h22;
        apply("bypass_load");
        chk("bypass_int1", 64'(rr_if.regs.srcIntRegValue1), BYP ? 64'h22 : 64'h11);
        chk("bypass_int2", 64'(rr_if.regs.srcIntRegValue2), 64'h33);

        // x0 reads zero even with a writeback to x0; f0 is a real register
        set_instr(32'h108, 5'd0, 5'd0, 5'd3);
        intRfData1 = 32'h55; intRfData2 = 32'h66;
        wbIntWe = 1'b1; wbIntAddr = 5'd0; wbIntValue = 32'h77;
        wbFpWe = 1'b1; wbFpAddr = 5'd0; wbFpValue = 64'h0F0F_0F0F_0F0F_0F0F;
        apply("zero_reg");
        chk("zero_int1", 64'(rr_if.regs.srcIntRegValue1), 64'h0);
        chk("f0_fp1", rr_if.regs.srcFpRegValue1, BYP ? 64'h0F0F_0F0F_0F0F_0F0F : 64'h1111_0000_0000_0001);

        // both sources hit the same writeback
        set_instr(32'h10C, 5'd9, 5'd9, 5'd4);
        wbIntWe = 1'b1; wbIntAddr = 5'd9; wbIntValue = 32'h99;
        wbFpWe = 1'b1; wbFpAddr = 5'd9; wbFpValue = 64'h9999_9999_0000_0009;
        apply("both_src");
        chk("both_int2", 64'(rr_if.regs.srcIntRegValue2), BYP ? 64'h99 : 64'h66);
        wb_off();

        // stall refresh of a held valid instruction
        set_instr(32'h200, 5'd3, 5'd7, 5'd8);
        intRfData1 = 32'hA1; intRfData2 = 32'hA2;
        fpRfData1 = 64'hF1; fpRfData2 = 64'hF2;
        apply("stall_load");
        set_instr(32'h300, 5'd1, 5'd2, 5'd3);
        stall = 1'b1;
        wbFpWe = 1'b1; wbFpAddr = 5'd7; wbFpValue = 64'hDEAD_BEEF_0000_0001;
        apply("stall_fp_refresh");
        chk("stall_pc", 64'(rr_if.regs.pc), 64'h200);
        chk("stall_fp2", rr_if.regs.srcFpRegValue2, BYP ? 64'hDEAD_BEEF_0000_0001 : 64'hF2);
        wb_off();
        wbIntWe = 1'b1; wbIntAddr = 5'd3; wbIntValue = 32'hC3;
        apply("stall_int_refresh");
        chk("stall_int1", 64'(rr_if.regs.srcIntRegValue1), BYP ? 64'hC3 : 64'hA1);
        wb_off();

        // flush beats stall; next clean cycle loads
        flush = 1'b1;
        apply("flush_stall");
        chk("flush_valid", 64'(rr_if.regs.valid), 64'h0);
        flush = 1'b0; stall = 1'b0;
        set_instr(32'h400, 5'd10, 5'd11, 5'd12);
        apply("after_flush");
        chk("after_flush_pc", 64'(rr_if.regs.pc), 64'h400);

        // invalid load, then stall with matching writeback must not refresh
        set_instr(32'h500, 5'd13, 5'd14, 5'd15);
        prevValid = 1'b0;
        apply("invalid_load");
        stall = 1'b1;
        wbIntWe = 1'b1; wbIntAddr = 5'd13; wbIntValue = 32'hBAD;
        apply("invalid_stall");
        stall = 1'b0; wb_off();

        // trap info passes through
        set_instr(32'h600, 5'd1, 5'd2, 5'd0);
        prevTrapInfo = '{valid: 1'b1, cause: 4'd2, value: 32'h600};
        apply("trap_pass");

        // asynchronous reset mid-stream, then recovery
        #3 rstN = 1'b0;
        #1;
        model = RegReadStageRegReset;
        chk_rr("midstream_reset", rr_if.regs, model);
        @(negedge clk);
        rstN = 1'b1;
        set_instr(32'h700, 5'd4, 5'd5, 5'd6);
        apply("post_reset_load");

        // random traffic with a narrow address range to provoke hazards
        for (int i = 0; i < 40; i++) begin
            prevValid = 1'($urandom_range(0, 1));
            prevOp = Op'($urandom_range(0, 7));
            prevPc = $urandom; prevInsn = $urandom;
            prevCsrAddr = 12'($urandom);
            prevSrcRegAddr1 = 5'($urandom_range(0, 3));
            prevSrcRegAddr2 = 5'($urandom_range(0, 3));
            prevDstRegAddr = 5'($urandom);
            prevTrapInfo = '{valid: 1'($urandom), cause: 4'($urandom), value: $urandom};
            intRfData1 = $urandom; intRfData2 = $urandom;
            fpRfData1 = {$urandom, $urandom}; fpRfData2 = {$urandom, $urandom};
            wbIntWe = 1'($urandom); wbIntAddr = 5'($urandom_range(0, 3)); wbIntValue = $urandom;
            wbFpWe = 1'($urandom); wbFpAddr = 5'($urandom_range(0, 3)); wbFpValue = {$urandom, $urandom};
            stall = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 9) == 0);
            apply("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Register-read pipeline stage between decode and execute. Captures one decoded instruction per cycle, reads the integer and FP register files, merges same-cycle writeback results, and drives the RegReadStage interface (ThisStage modport) from a single pipeline register. Supports stall (hold) and flush (kill), and refreshes held operands while stalled so a stalled instruction never carries stale values.

## Interface
Parameters:
- none; widths come from shared types (word_t = 32, uint64_t = 64, reg_addr_t = 5).

Ports:
- clk  in  1  clock, all state on rising edge
- rstN  in  1  reset, asynchronous, active-low
- prevValid  in  1  decode-stage instruction valid
- prevOp  in  Op  decoded op
- prevPc, prevInsn  in  32 each  PC and raw instruction
- prevCsrAddr  in  12  CSR address
- prevSrcRegAddr1/2, prevDstRegAddr  in  5 each  register addresses
- prevTrapInfo  in  TrapInfo  trap detected upstream
- intRfAddr1/2  out  5 each  integer RF read addresses (= prevSrcRegAddr1/2)
- intRfData1/2  in  32 each  integer RF read data, combinational
- fpRfAddr1/2  out  5 each  FP RF read addresses (= prevSrcRegAddr1/2)
- fpRfData1/2  in  64 each  FP RF read data, combinational
- wbIntWe, wbIntAddr, wbIntValue  in  1/5/32  integer writeback port
- wbFpWe, wbFpAddr, wbFpValue  in  1/5/64  FP writeback port
- stall  in  1  hold pipeline register
- flush  in  1  kill current and incoming instruction
- nextStage  ThisStage modport of RegReadStageIF  registered outputs

## Operation
- Pipeline register fields: valid, op, pc, insn, csrAddr, srcRegAddr1/2, dstRegAddr, srcIntRegValue1/2, srcFpRegValue1/2, trapInfo.
- Reset (rstN low, async): valid=0, every other field 0, trapInfo all zero.
- Priority per edge: flush > stall > load.
  - flush: valid<=0; other fields don't-care (implementation clears to 0).
  - stall (no flush): all fields hold, except operand refresh below.
  - load: all fields <= prev* values; operands <= resolved values.
- Operand resolution at load (per source n):
  - int: addr==0 -> 0; else wbIntWe && wbIntAddr==addr -> wbIntValue; else intRfData.
  - fp: wbFpWe && wbFpAddr==addr -> wbFpValue; else fpRfData (f0 is a real register).
- Operand refresh during stall: if valid, wbIntWe, wbIntAddr!=0 and wbIntAddr==srcRegAddrN -> srcIntRegValueN<=wbIntValue; same for FP with wbFpAddr (no zero exclusion).
- Both sources matching same writeback: both updated.
- prevValid=0 at load: valid<=0, fields still loaded (harmless).
- Trap instructions pass through unchanged; no RF-related suppression.

## Timing
- Latency 1 cycle: prev* sampled at edge N appear on nextStage at N+1.
- RF read is combinational, same cycle as load; writeback in same cycle wins over RF data.
- Throughput 1 instr/cycle when stall=0.
- Reset deasserted mid-stream: first load on first edge after rstN high.
- flush and stall both high: flush wins, valid=0 next cycle.

## Configuration
- RAFI_REG_READ_BYPASS_EN defined: writeback merge at load and operand refresh during stall as above.
- Undefined: operands always from RF (int addr 0 still forced 0); no refresh while stalled; upstream hazard logic must stall until writeback has committed. Port list unchanged; wb* inputs ignored.

## Structure
- Shared package (ProcessorTypes): RegReadStageReg struct (all pipeline register fields), ZeroRegAddr constant, reset-value constant for TrapInfo.
- One sub-module: reg_read_bypass (combinational: RF data + writeback + address -> resolved int/fp value); instantiated twice (sources 1, 2) and reused for stall refresh.

## Test plan
- Reset: rstN low mid-cycle -> valid=0, pc=0 immediately, without a clock edge.
- Basic load: prevValid=1, pc=0x100, src1=5, intRfData1=0x11 -> next cycle valid=1, pc=0x100, srcIntRegValue1=0x11.
- Bypass (EN): src1=5, intRfData1=0x11, wbIntWe=1, wbIntAddr=5, wbIntValue=0x22 -> srcIntRegValue1=0x22; src=0 with wbIntAddr=0 -> value 0.
- Stall refresh (EN): valid instr src2=7 held by stall=1; wbFpWe=1, wbFpAddr=7, wbFpValue=0xDEAD_BEEF_0000_0001 -> srcFpRegValue2 updated, pc unchanged.
- Flush priority: stall=1 and flush=1 -> valid=0 next cycle; following cycle with both low loads new instr.
- Bypass disabled build: same stimulus as bypass test -> srcIntRegValue1=0x11.
